// File: rtl/dp_pkg.sv
// Shared helpers for the datapath arbiter library: index-width sizing and the
// packed-slice convention used for multi-requester operand buses.
package dp_pkg;

    // Ceiling log2 with a floor of 1 so a requester index is never zero-width.
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Requester i occupies bits [i*width +: width] of a packed operand bus.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/SINC.sv
// Signed incrementer: two's-complement wrap, flags the max-positive operand.
module SINC #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         ovf_o
);

    localparam logic signed [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] One    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    assign y_o   = a_i + One;
    assign ovf_o = (a_i == MaxPos);

endmodule

// File: rtl/sinc_rr_arbiter.sv
// Round-robin arbiter sharing one SINC incrementer among NUM_REQ requesters,
// with a single-entry valid/ready result register.
module sinc_rr_arbiter
    import dp_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = clog2(NUM_REQ)
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic signed [DATA_WIDTH-1:0]    rsp_data,
    output logic                            rsp_ovf
);

    localparam int unsigned NR = NUM_REQ;
    localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]              ptr_q, ptr_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]              rsp_id_q, rsp_id_d;
    logic signed [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                         rsp_ovf_q, rsp_ovf_d;

    logic                         found;
    logic [ID_W-1:0]              winner;
    logic signed [DATA_WIDTH-1:0] operand;
    logic signed [DATA_WIDTH-1:0] sum;
    logic                         sum_ovf;
    logic                         accept;
    logic                         grant;
    int unsigned                  idx;
    logic [ID_W-1:0]              idx_w;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; explicit wrap keeps non-power-of-2 counts correct.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        operand = '0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NR) begin
                idx = idx - NR;
            end
            idx_w = ID_W'(idx);
            if (!found && req[idx_w]) begin
                found   = 1'b1;
                winner  = idx_w;
                operand = req_data[slice_lsb(idx, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    assign accept = !rsp_valid_q || rsp_ready;
    assign grant  = Rst_n && accept && found;

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[winner] = 1'b1;
        end
    end

    SINC #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sinc (
        .a_i   (operand),
        .y_o   (sum),
        .ovf_o (sum_ovf)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (grant) begin
            ptr_d       = (winner == LastId) ? '0 : winner + 1'b1;
            rsp_valid_d = 1'b1;
            rsp_id_d    = winner;
            rsp_data_d  = sum;
            rsp_ovf_d   = sum_ovf;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: doc/sinc_rr_arbiter.md
# sinc_rr_arbiter

Round-robin arbiter and sequencer that shares a single signed incrementer datapath unit (`SINC`) among `NUM_REQ` requesters. Each requester presents a signed operand with a request line. The block grants one requester per cycle and registers the incremented result with the winner's ID. The result is presented on a valid/ready response port. It sits between the scheduled-datapath control logic and the shared `SINC` instance.

## Interface
- `DATA_WIDTH`, 8, operand/result width (signed two's complement).
- `NUM_REQ`, 4, number of requesters; range 2..16.
- `ID_W`, `clog2(NUM_REQ)`, requester-index width; derived, not overridden.

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-requester request; held high with data stable until granted.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  packed signed operands; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  `NUM_REQ`  one-hot combinational grant; operand is consumed at the edge where `gnt[i]` is high.
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  consumer accepts the result this cycle.
- `rsp_id`  out  `ID_W`  index of the requester that produced the result.
- `rsp_data`  out  `DATA_WIDTH`  signed result, operand + 1.
- `rsp_ovf`  out  1  set when the operand was +2^(DATA_WIDTH-1)-1, i.e. the result wrapped to the most negative value.

## Operation
- `accept = !rsp_valid || rsp_ready`: the result register is empty or drains this cycle.
- Pointer `ptr` (`ID_W` bits) marks highest-priority requester. Winner is the first i with `req[i]=1`, scanning ptr, ptr+1, … modulo `NUM_REQ`.
- `gnt` = one-hot(winner) when `accept && |req`; otherwise all zero. `gnt` is 0 while `Rst_n` is low.
- On grant edge:
  - `rsp_data` <= SINC(`req_data[winner]`).
  - `rsp_id` <= winner.
  - `rsp_ovf` <= (operand == max positive).
  - `rsp_valid` <= 1.
  - `ptr` <= (winner+1) mod `NUM_REQ`. Wraps from `NUM_REQ-1` to 0, including non-power-of-2 `NUM_REQ`.
- No grant and `rsp_ready`: `rsp_valid` <= 0; data/id/ovf hold last values.
- No grant and not `rsp_ready` (stall): all response outputs hold.
- `ptr` changes only on a grant. Idle cycles do not rotate priority.
- Arithmetic: result width = `DATA_WIDTH`; two's-complement wrap, no saturation. −1 → 0 and −128 → −127 (8-bit) are normal, with `rsp_ovf` = 0.
- A requester dropping `req` without a grant is legal; no state is kept per requester.

## Timing
- Reset (async assert, any cycle, including mid-stall): `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_ovf`=0, `ptr`=0. Any in-flight result is discarded. Deassertion is synchronised externally; the first grant is possible on the first edge after release.
- Latency: grant edge → `rsp_valid` high the next cycle (1 cycle).
- Throughput: one result per cycle while `rsp_ready`=1 and any `req` is high.
- Simultaneous drain and grant (`rsp_valid && rsp_ready && |req`): the old result is consumed and the new result is loaded at the same edge, with no bubble.
- Backpressure: while `rsp_valid && !rsp_ready`, `gnt`=0 and all requests wait.
- Fairness: a continuously asserting requester is granted within `NUM_REQ` grants.

## Structure
- Shared package/header `dp_pkg`: constant function `clog2`, and the packed-slice convention for `req_data`. Other arbiters in the datapath library reuse these.
- Sub-module: one instance of the existing `SINC #(DATA_WIDTH)`, fed by the winner-selected operand mux. The round-robin pick logic stays inline.
- Registers: `ptr`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_ovf` only.

## Test plan
- Reset then `req`=4'b0001, operand 5, `rsp_ready`=1 → `gnt`=0001. Next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_data`=6, `rsp_ovf`=0, `ptr`=1.
- `req`=4'b1111 held, `rsp_ready`=1, operands 10,20,30,40 → grants 0,1,2,3,0 on consecutive cycles. Results 11,21,31,41,11 back-to-back with no bubbles.
- Operand 127 on req 2 (8-bit) → `rsp_data`=−128, `rsp_ovf`=1. Operand −1 → 0, `rsp_ovf`=0. Operand −128 → −127.
- `rsp_ready`=0 for 3 cycles with `req`=4'b0110 → `gnt`=0 and outputs hold during the stall. On `rsp_ready`=1, same-cycle drain-and-grant of req 1 (ptr=1).
- `ptr`=3, `req`=4'b0101 → req 0 granted, `ptr`=1. Then req 2 is granted before req 0 is re-granted.
- Assert `Rst_n` low while `rsp_valid`=1 and stalled → all outputs 0 immediately (asynchronous). After release, `ptr`=0 and `req`=4'b1000 is granted with `rsp_id`=3.
